display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller_if.sv | 23 ++
 rtl/display_scan_controller.sv | 119 +++++++++++
 tb/tb_display_scan_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_if.sv
// Digit load/scan bundle between a number source and the display scanner.
// The source drives load and d0..d3; the scanner drives the display-side outputs.
interface display_scan_controller_if;
  logic       load;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] numero;
  logic [3:0] seleccion;
  logic       blank;
  logic       frame_done;

  modport master (
    output load, d0, d1, d2, d3,
    input  numero, seleccion, blank, frame_done
  );

  modport slave (
    input  load, d0, d1, d2, d3,
    output numero, seleccion, blank, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-seg scanner with per-slot anti-ghost blanking and frame-synchronous digit updates.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_controller #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                       CLK,
  input  logic                       RST,
  display_scan_controller_if.slave   bus
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0][3:0]  active_q, active_d;
  logic             pending_q, pending_d;
  logic [3:0]       numero_q, numero_d;
  logic [3:0]       seleccion_q, seleccion_d;
  logic             blank_q, blank_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0][3:0]  din;
  logic             slot_end;
  logic             frame_wrap;
  logic             show;

  assign din        = {bus.d3, bus.d2, bus.d1, bus.d0};
  assign slot_end   = (state_q == ST_SHOW) && (cnt_q == CNT_W'(PRESCALE - 1));
  assign frame_wrap = slot_end && (idx_q == 2'd3);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      numero_q     <= '0;
      seleccion_q  <= 4'b1111;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      numero_q     <= numero_d;
      seleccion_q  <= seleccion_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYC - 1)) state_d = ST_SHOW;
      end
      default: begin
        if (slot_end) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase
    // A load landing exactly on the frame boundary bypasses the shadow stage.
    if (frame_wrap && bus.load) begin
      active_d  = din;
      shadow_d  = din;
      pending_d = 1'b0;
    end else begin
      if (frame_wrap && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (bus.load) begin
        shadow_d  = din;
        pending_d = 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so they register in step with the FSM.
  always_comb begin
    numero_d     = active_d[idx_d];
    frame_done_d = frame_wrap;
    show         = (state_d == ST_SHOW);
`ifdef DISPLAY_SCAN_LZB_EN
    case (idx_d)
      2'd1:    if (active_d[3] == 4'd0 && active_d[2] == 4'd0 && active_d[1] == 4'd0) show = 1'b0;
      2'd2:    if (active_d[3] == 4'd0 && active_d[2] == 4'd0) show = 1'b0;
      2'd3:    if (active_d[3] == 4'd0) show = 1'b0;
      default: ;
    endcase
`endif
    seleccion_d = show ? ~(4'b0001 << idx_d) : 4'b1111;
    blank_d     = ~show;
  end

  assign bus.numero     = numero_q;
  assign bus.seleccion  = seleccion_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed-vector bench for display_scan_controller at PRESCALE=8, BLANK_CYC=2.
module tb_display_scan_controller;

  logic CLK = 1'b0;
  logic RST = 1'b1;

`ifdef DISPLAY_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  display_scan_controller_if bus();

  display_scan_controller #(.PRESCALE(8), .BLANK_CYC(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         adv;
    bit         ld;
    logic [15:0] dv;
    logic [3:0] sel;
    bit         blk;
    logic [3:0] num;
    bit         fd;
    bit         lz;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input int adv, input bit ld, input logic [15:0] dv,
                     input logic [3:0] sel, input bit blk, input logic [3:0] num,
                     input bit fd, input bit lz);
    vec_t v;
    v.adv = adv; v.ld = ld; v.dv = dv; v.sel = sel;
    v.blk = blk; v.num = num; v.fd = fd; v.lz = lz;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] sel, input bit blk,
                       input logic [3:0] num, input bit fd);
    n_vec++;
    if (bus.seleccion !== sel || bus.blank !== blk || bus.numero !== num || bus.frame_done !== fd) begin
      n_bad++;
      $display("FAIL %s: got sel=%b blank=%b numero=%h frame_done=%b, want sel=%b blank=%b numero=%h frame_done=%b",
               name, bus.seleccion, bus.blank, bus.numero, bus.frame_done, sel, blk, num, fd);
    end else begin
      $display("ok   %s: sel=%b blank=%b numero=%h frame_done=%b",
               name, bus.seleccion, bus.blank, bus.numero, bus.frame_done);
    end
  endtask

  task automatic drive(input bit ld, input logic [15:0] dv);
    bus.load = ld;
    bus.d3 = dv[15:12];
    bus.d2 = dv[11:8];
    bus.d1 = dv[7:4];
    bus.d0 = dv[3:0];
  endtask

  initial begin
    logic [3:0] esel;
    bit         eblk;
    int         c;
    int         ix;

    drive(1'b0, 16'h0000);
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    check("reset", 4'b1111, 1'b1, 4'h0, 1'b0);

    // k = cycles since the last reset edge
    add(1, 0, 16'h0000, 4'b1111, 1, 4'h0, 0, 0); // k1
    add(1, 0, 16'h0000, 4'b1110, 0, 4'h0, 0, 0); // k2 first anode
    add(5, 0, 16'h0000, 4'b1110, 0, 4'h0, 0, 0); // k7
    add(1, 0, 16'h0000, 4'b1111, 1, 4'h0, 0, 0); // k8
    add(2, 0, 16'h0000, 4'b1101, 0, 4'h0, 0, 1); // k10
    add(1, 1, 16'h1234, 4'b1101, 0, 4'h0, 0, 1); // k11 load in digit-1 slot
    add(5, 0, 16'h0000, 4'b1111, 1, 4'h0, 0, 0); // k16
    add(2, 0, 16'h0000, 4'b1011, 0, 4'h0, 0, 1); // k18
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h0, 0, 0); // k24
    add(7, 0, 16'h0000, 4'b0111, 0, 4'h0, 0, 1); // k31
    add(1, 0, 16'h0000, 4'b1111, 1, 4'h4, 1, 0); // k32 boundary
    add(1, 0, 16'h0000, 4'b1111, 1, 4'h4, 0, 0); // k33
    add(1, 0, 16'h0000, 4'b1110, 0, 4'h4, 0, 0); // k34
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h3, 0, 0); // k40
    add(2, 0, 16'h0000, 4'b1101, 0, 4'h3, 0, 0); // k42
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h2, 0, 0); // k48
    add(2, 0, 16'h0000, 4'b1011, 0, 4'h2, 0, 0); // k50
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h1, 0, 0); // k56
    add(2, 0, 16'h0000, 4'b0111, 0, 4'h1, 0, 0); // k58
    add(1, 1, 16'h5555, 4'b0111, 0, 4'h1, 0, 0); // k59 pending 5555
    add(4, 0, 16'h0000, 4'b0111, 0, 4'h1, 0, 0); // k63
    add(1, 1, 16'h9876, 4'b1111, 1, 4'h6, 1, 0); // k64 load on boundary
    add(2, 0, 16'h0000, 4'b1110, 0, 4'h6, 0, 0); // k66
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h7, 0, 0); // k72
    add(2, 0, 16'h0000, 4'b1101, 0, 4'h7, 0, 0); // k74
    add(8, 0, 16'h0000, 4'b1011, 0, 4'h8, 0, 0); // k82
    add(8, 0, 16'h0000, 4'b0111, 0, 4'h9, 0, 0); // k90
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h6, 1, 0); // k96 pending was cleared
    add(1, 1, 16'h0400, 4'b1111, 1, 4'h6, 0, 0); // k97 load d2=4
    add(1, 0, 16'h0000, 4'b1110, 0, 4'h6, 0, 0); // k98
    add(30, 0, 16'h0000, 4'b1111, 1, 4'h0, 1, 0); // k128
    add(2, 0, 16'h0000, 4'b1110, 0, 4'h0, 0, 0); // k130 digit 0 zero shown
    add(8, 0, 16'h0000, 4'b1101, 0, 4'h0, 0, 0); // k138
    add(8, 0, 16'h0000, 4'b1011, 0, 4'h4, 0, 0); // k146
    add(8, 0, 16'h0000, 4'b0111, 0, 4'h0, 0, 1); // k154 leading zero
    add(6, 0, 16'h0000, 4'b1111, 1, 4'h0, 1, 0); // k160

    foreach (vt[i]) begin
      drive(vt[i].ld, vt[i].dv);
      tick();
      drive(1'b0, 16'h0000);
      repeat (vt[i].adv - 1) tick();
      if (LZB && vt[i].lz) check($sformatf("vec%0d", i), 4'b1111, 1'b1, vt[i].num, vt[i].fd);
      else                 check($sformatf("vec%0d", i), vt[i].sel, vt[i].blk, vt[i].num, vt[i].fd);
    end

    // Mid-slot reset during digit-2 SHOW with a load pending.
    drive(1'b1, 16'h1111);
    tick();                      // k161
    drive(1'b0, 16'h0000);
    repeat (17) tick();          // k178
    check("pre_rst_d2", 4'b1011, 1'b0, 4'h4, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midslot_rst", 4'b1111, 1'b1, 4'h0, 1'b0);

    // Free-run after reset with all-zero active digits; pending must be gone.
    for (int k = 1; k <= 40; k++) begin
      tick();
      c  = k % 8;
      ix = (k / 8) % 4;
      eblk = !(c >= 2 && !(LZB && ix != 0));
      esel = eblk ? 4'b1111 : ~(4'b0001 << ix);
      check($sformatf("post_rst_k%0d", k), esel, eblk, 4'h0, (k % 32) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
